// File: rtl/vector_store_unit_if.sv
// ---------------------------------------------------------------------------
// vector_store_unit_if
//
// Purpose:
//   Groups the control handshake and the memory write port of the vector
//   store unit into one bundle.
//
// Signals:
//   start            1       single-cycle store request
//   reg_select       2       source register: 00=A1, 01=A2, 10=A3, 11=A4
//   base_addr        ADDR_W  word address of the first (lowest) word
//   mem_write_enable 1       write request valid
//   mem_addr         ADDR_W  word address of the current beat
//   mem_data_out     WORD_W  data of the current beat
//   mem_ready        1       memory accepts the beat this cycle
//   busy             1       store in progress
//   done             1       one-cycle pulse after the last beat is accepted
//
// Modports:
//   master : the requester / memory side (drives start, reg_select,
//            base_addr, mem_ready)
//   slave  : the store unit itself
//
// ADDR_W and WORD_W must match the parameters of the attached store unit.
// ---------------------------------------------------------------------------
interface vector_store_unit_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
);
    logic              start;
    logic [1:0]        reg_select;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data_out;
    logic              mem_ready;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output reg_select,
        output base_addr,
        output mem_ready,
        input  mem_write_enable,
        input  mem_addr,
        input  mem_data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  reg_select,
        input  base_addr,
        input  mem_ready,
        output mem_write_enable,
        output mem_addr,
        output mem_data_out,
        output busy,
        output done
    );
endinterface

// File: rtl/vector_store_unit.sv
// ---------------------------------------------------------------------------
// vector_store_unit
//
// Purpose:
//   Stores one DATA_W-bit vector register (A1..A4) to word-addressed memory
//   as NBEATS consecutive WORD_W-bit words, lowest word first. The selected
//   register is snapshotted when the store starts, so later register-file
//   writes never leak into the stored data.
//
// Ports:
//   clk    1       clock, rising edge
//   rst_n  1       synchronous active-low reset
//   A1..A4 DATA_W  register file outputs
//   bus    slave   control handshake + memory write port (see interface)
//
// Timing with mem_ready held high: start sampled at the end of cycle 0,
// beats presented and accepted in cycles 1..NBEATS, done in cycle NBEATS+1,
// next start accepted from cycle NBEATS+2. Every output is a flop.
// ---------------------------------------------------------------------------
module vector_store_unit #(
    parameter int DATA_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   A1,
    input  logic [DATA_W-1:0]   A2,
    input  logic [DATA_W-1:0]   A3,
    input  logic [DATA_W-1:0]   A4,
    vector_store_unit_if.slave  bus
);
    // DATA_W must be an integer multiple of WORD_W.
    localparam int NBEATS = DATA_W / WORD_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0]  snap_q, snap_d;
    logic [ADDR_W-1:0]  base_q, base_d;

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Register file source mux.
    logic [DATA_W-1:0]  src_sel;
    always_comb begin
        src_sel = A1;
        case (bus.reg_select)
            2'b00:   src_sel = A1;
            2'b01:   src_sel = A2;
            2'b10:   src_sel = A3;
            default: src_sel = A4;
        endcase
    end

    // Word views of the snapshot and of the live source, so the beat data
    // mux is a plain array index.
    logic [WORD_W-1:0] snap_words [NBEATS];
    logic [WORD_W-1:0] src_word0;

    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_words
            assign snap_words[gi] = snap_q[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign src_word0 = src_sel[WORD_W-1:0];

    logic [BEAT_W-1:0] beat_inc;
    logic              accept;

    assign beat_inc = beat_q + BEAT_W'(1);
    // A beat only counts when it is actually on the bus; mem_ready alone
    // outside a store is meaningless.
    assign accept   = we_q & bus.mem_ready;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        snap_d  = snap_q;
        base_d  = base_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                we_d   = 1'b0;
                addr_d = '0;
                data_d = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    // Beat 0 is driven straight from the live source so it
                    // appears on the bus the cycle after start, in step with
                    // the snapshot being captured.
                    snap_d  = src_sel;
                    base_d  = bus.base_addr;
                    beat_d  = '0;
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = bus.base_addr;
                    data_d  = src_word0;
                end
            end

            S_WRITE: begin
                // Without acceptance everything holds: the request is never
                // retracted and address/data stay stable.
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_inc;
                        // Address wraps naturally at ADDR_W bits.
                        addr_d = base_q + ADDR_W'(beat_inc);
                        data_d = snap_words[beat_inc];
                    end
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here; it has to be
                // reasserted once back in IDLE.
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                addr_d  = '0;
                data_d  = '0;
            end

            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                addr_d  = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            snap_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
            base_q  <= base_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_write_enable = we_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_data_out     = data_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

endmodule
